// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: ID-stage control decoder with a registered ID/EX control word.
// Decodes {mode, op_code, S, I} into the execute control word. The ARM condition
// field is checked against NZCV. The result is latched with freeze/flush handling.
// A small down-counter squashes the slots in the shadow of a taken branch.
//
// Build option: define COND_CHECK_EN to evaluate cond against nzcv and latch a
// bubble on a failed condition. Without it, cond and nzcv are ignored and every
// instruction passes.
//
// CMD_W must be at least 4. The 4-bit command is zero-extended into exe_cmd.
module ctrl_decode_stage #(
  parameter int unsigned CMD_W     = 4,
  parameter int unsigned BR_SHADOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       op_code,
  input  logic [1:0]       mode,
  input  logic             s_in,
  input  logic             i_in,
  input  logic [3:0]       nzcv,
  input  logic             freeze,
  input  logic             flush,
  output logic             out_valid,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic             b_out,
  output logic             s_out,
  output logic             undef
);

  // ALU command encodings
  localparam logic [3:0] CmdNop = 4'b0000;
  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;

  // Instruction classes
  localparam logic [1:0] ModeData = 2'b00;
  localparam logic [1:0] ModeMem  = 2'b01;
  localparam logic [1:0] ModeBr   = 2'b10;

  localparam logic [1:0] ShadowLoad = BR_SHADOW[1:0];

  typedef struct packed {
    logic       valid;
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic       undef;
  } ctrl_t;

  localparam ctrl_t Bubble = '0;

  ctrl_t      dec;
  logic       dec_undef;
  logic       dec_branch;
  logic       cond_pass;
  ctrl_t      ctrl_d, ctrl_q;
  logic [1:0] sc_d, sc_q;

  // Combinational decode of the instruction fields into a control word
  always_comb begin
    dec        = Bubble;
    dec.valid  = 1'b1;
    dec_undef  = 1'b0;
    dec_branch = 1'b0;
    unique case (mode)
      ModeData: begin
        dec.wb_en = 1'b1;
        dec.s     = s_in;
        case (op_code)
          4'b1101: dec.cmd = CmdMov;
          4'b1111: dec.cmd = CmdMvn;
          4'b0100: dec.cmd = CmdAdd;
          4'b0101: dec.cmd = CmdAdc;
          4'b0010: dec.cmd = CmdSub;
          4'b0110: dec.cmd = CmdSbc;
          4'b0000: dec.cmd = CmdAnd;
          4'b1100: dec.cmd = CmdOrr;
          4'b0001: dec.cmd = CmdEor;
          4'b1010: begin
            // CMP: flags only
            dec.cmd   = CmdSub;
            dec.wb_en = 1'b0;
            dec.s     = 1'b1;
          end
          4'b1000: begin
            // TST: flags only
            dec.cmd   = CmdAnd;
            dec.wb_en = 1'b0;
            dec.s     = 1'b1;
          end
          default: dec_undef = 1'b1;
        endcase
      end
      ModeMem: begin
        if (op_code == 4'b0100) begin
          dec.cmd = CmdAdd;
          if (s_in) begin
            dec.wb_en    = 1'b1;
            dec.mem_r_en = 1'b1;
          end else begin
            dec.mem_w_en = 1'b1;
          end
        end else begin
          dec_undef = 1'b1;
        end
      end
      ModeBr: begin
        if (i_in) begin
          dec.b      = 1'b1;
          dec.cmd    = CmdNop;
          dec_branch = 1'b1;
        end else begin
          dec_undef = 1'b1;
        end
      end
      default: dec_undef = 1'b1;
    endcase

    if (dec_undef) begin
      dec       = Bubble;
      dec.valid = 1'b1;
      dec.undef = 1'b1;
    end
  end

`ifdef COND_CHECK_EN
  // ARM condition evaluation against {N,Z,C,V}
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    unique case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{cond, nzcv};

  // Condition checking disabled: every instruction passes
  always_comb begin
    cond_pass = 1'b1;
  end
`endif

  // Next-state selection: flush > freeze > idle slot > shadow squash > cond fail > latch
  always_comb begin
    ctrl_d = ctrl_q;
    sc_d   = sc_q;
    if (flush) begin
      ctrl_d = Bubble;
      sc_d   = 2'd0;
    end else if (freeze) begin
      ctrl_d       = ctrl_q;
      ctrl_d.undef = 1'b0;
    end else if (!in_valid) begin
      ctrl_d = Bubble;
    end else if (sc_q != 2'd0) begin
      // Branch shadow: squash and consume one slot, even if this is a branch
      ctrl_d = Bubble;
      sc_d   = sc_q - 2'd1;
    end else if (!cond_pass) begin
      ctrl_d = Bubble;
    end else begin
      ctrl_d = dec;
      if (dec_branch) begin
        sc_d = ShadowLoad;
      end
    end
  end

  // ID/EX control register and shadow counter, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= Bubble;
      sc_q   <= 2'd0;
    end else begin
      ctrl_q <= ctrl_d;
      sc_q   <= sc_d;
    end
  end

  // Registered outputs, command zero-extended to CMD_W
  always_comb begin
    exe_cmd      = '0;
    exe_cmd[3:0] = ctrl_q.cmd;
    out_valid    = ctrl_q.valid;
    wb_en        = ctrl_q.wb_en;
    mem_r_en     = ctrl_q.mem_r_en;
    mem_w_en     = ctrl_q.mem_w_en;
    b_out        = ctrl_q.b;
    s_out        = ctrl_q.s;
    undef        = ctrl_q.undef;
  end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage (CMD_W=6, BR_SHADOW=2).
// The driver pushes hand-computed expectations. A monitor pops one expectation
// 1 time unit after each rising edge and compares it with the outputs.
module tb_ctrl_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, s_in, i_in, freeze, flush;
  logic [3:0] cond, op_code, nzcv;
  logic [1:0] mode;
  logic       out_valid, wb_en, mem_r_en, mem_w_en, b_out, s_out, undef;
  logic [5:0] exe_cmd;

  int checks   = 0;
  int failures = 0;

  string       name_q[$];
  logic [12:0] exp_q[$];

  ctrl_decode_stage #(
    .CMD_W    (6),
    .BR_SHADOW(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .cond     (cond),
    .op_code  (op_code),
    .mode     (mode),
    .s_in     (s_in),
    .i_in     (i_in),
    .nzcv     (nzcv),
    .freeze   (freeze),
    .flush    (flush),
    .out_valid(out_valid),
    .exe_cmd  (exe_cmd),
    .wb_en    (wb_en),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .b_out    (b_out),
    .s_out    (s_out),
    .undef    (undef)
  );

  always #5 clk = ~clk;

  // Expected output vector {valid, cmd(6), wb, mr, mw, b, s, undef}
  function automatic logic [12:0] ex(input logic v, input logic [3:0] c, input logic wb,
                                     input logic mr, input logic mw, input logic b,
                                     input logic s, input logic u);
    return {v, 2'b00, c, wb, mr, mw, b, s, u};
  endfunction

  localparam logic [12:0] BUB = 13'd0;
  localparam logic [3:0]  AL  = 4'b1110;

  // Drive one slot at the falling edge and queue its expected response
  task automatic step(input string nm, input logic r, input logic v, input logic [3:0] cd,
                      input logic [1:0] md, input logic [3:0] op, input logic s,
                      input logic i, input logic [3:0] nz, input logic fz, input logic fl,
                      input logic [12:0] e);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    cond     = cd;
    mode     = md;
    op_code  = op;
    s_in     = s;
    i_in     = i;
    nzcv     = nz;
    freeze   = fz;
    flush    = fl;
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  // Monitor: compare one queued expectation per rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      string       nm;
      logic [12:0] e, act;
      nm  = name_q.pop_front();
      e   = exp_q.pop_front();
      act = {out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b_out, s_out, undef};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %b want %b", nm, act, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cond = AL; mode = 2'b00; op_code = 4'b0;
    s_in = 1'b0; i_in = 1'b0; nzcv = 4'b0; freeze = 1'b0; flush = 1'b0;

    // Reset with a live ADD on the inputs
    step("rst0", 0, 1, AL, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, BUB);
    step("rst1", 0, 1, AL, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, BUB);
    step("add_s", 1, 1, AL, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0, ex(1, 4'b0010, 1, 0, 0, 0, 1, 0));
`ifdef COND_CHECK_EN
    step("sub_eq_fail", 1, 1, 4'b0000, 2'b00, 4'b0010, 0, 0, 4'h0, 0, 0, BUB);
`else
    step("sub_eq_nochk", 1, 1, 4'b0000, 2'b00, 4'b0010, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0100, 1, 0, 0, 0, 0, 0));
`endif
    step("sub_eq_pass", 1, 1, 4'b0000, 2'b00, 4'b0010, 0, 0, 4'b0100, 0, 0,
         ex(1, 4'b0100, 1, 0, 0, 0, 0, 0));
    step("cmp", 1, 1, AL, 2'b00, 4'b1010, 0, 0, 4'h0, 0, 0, ex(1, 4'b0100, 0, 0, 0, 0, 1, 0));
    step("tst", 1, 1, AL, 2'b00, 4'b1000, 0, 0, 4'h0, 0, 0, ex(1, 4'b0110, 0, 0, 0, 0, 1, 0));
    step("mvn", 1, 1, AL, 2'b00, 4'b1111, 1, 0, 4'h0, 0, 0, ex(1, 4'b1001, 1, 0, 0, 0, 1, 0));
    step("eor", 1, 1, AL, 2'b00, 4'b0001, 0, 0, 4'h0, 0, 0, ex(1, 4'b1000, 1, 0, 0, 0, 0, 0));
    step("ldr", 1, 1, AL, 2'b01, 4'b0100, 1, 0, 4'h0, 0, 0, ex(1, 4'b0010, 1, 1, 0, 0, 0, 0));
    step("str", 1, 1, AL, 2'b01, 4'b0100, 0, 0, 4'h0, 0, 0, ex(1, 4'b0010, 0, 0, 1, 0, 0, 0));
    step("mem_undef", 1, 1, AL, 2'b01, 4'b0011, 0, 0, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 0, 0, 1));
    step("idle_after_undef", 1, 0, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);

    // Branch shadow of two
    step("b1", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 1, 0, 0));
    step("shadow1", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("shadow2", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("add_after_shadow", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    // Idle slot keeps sc; branch in shadow does not reload
    step("b2", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 1, 0, 0));
    step("idle_in_shadow", 1, 0, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("b_in_shadow", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, BUB);
    step("shadow_last", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("add_no_reload", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));

    // Freeze holds with changing inputs
    step("orr", 1, 1, AL, 2'b00, 4'b1100, 0, 0, 4'h0, 0, 0, ex(1, 4'b0111, 1, 0, 0, 0, 0, 0));
    step("frz1", 1, 1, AL, 2'b01, 4'b0100, 0, 0, 4'h0, 1, 0, ex(1, 4'b0111, 1, 0, 0, 0, 0, 0));
    step("frz2", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 1, 0, ex(1, 4'b0111, 1, 0, 0, 0, 0, 0));
    step("frz3", 1, 1, AL, 2'b11, 4'b0011, 1, 1, 4'hF, 1, 0, ex(1, 4'b0111, 1, 0, 0, 0, 0, 0));
    step("undef_m11", 1, 1, AL, 2'b11, 4'b0000, 0, 0, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 0, 0, 1));
    step("frz_undef_drop", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 1, 0,
         ex(1, 4'b0, 0, 0, 0, 0, 0, 0));

    // Flush beats freeze and clears the shadow counter
    step("b3", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 1, 0, 0));
    step("flush_frz", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 1, 1, BUB);
    step("add_after_flush", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));

    // Reset in the middle of a shadow
    step("b4", 1, 1, AL, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, ex(1, 4'b0, 0, 0, 0, 1, 0, 0));
    step("rst_mid_shadow", 0, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("add_after_rst", 1, 1, AL, 2'b00, 4'b0100, 1, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 1, 0));

`ifdef COND_CHECK_EN
    step("cond_nv", 1, 1, 4'b1111, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("b_fail", 1, 1, 4'b0000, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0, BUB);
    step("add_no_shadow", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    step("add_no_shadow2", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    step("undef_cond_fail", 1, 1, 4'b0000, 2'b11, 4'b0000, 0, 0, 4'h0, 0, 0, BUB);
    step("gt_pass", 1, 1, 4'b1100, 2'b00, 4'b0100, 0, 0, 4'b0000, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    step("lt_pass", 1, 1, 4'b1011, 2'b00, 4'b0100, 0, 0, 4'b1000, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    step("hi_fail", 1, 1, 4'b1000, 2'b00, 4'b0100, 0, 0, 4'b0110, 0, 0, BUB);
    step("cs_fail", 1, 1, 4'b0010, 2'b00, 4'b0100, 0, 0, 4'b0000, 0, 0, BUB);
`else
    step("cond_nv_nochk", 1, 1, 4'b1111, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
    step("b_nochk", 1, 1, 4'b0000, 2'b10, 4'b0000, 0, 1, 4'h0, 0, 0,
         ex(1, 4'b0, 0, 0, 0, 1, 0, 0));
    step("shadow_nochk1", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("shadow_nochk2", 1, 1, AL, 2'b00, 4'b0100, 0, 0, 4'h0, 0, 0, BUB);
    step("undef_nochk", 1, 1, 4'b0000, 2'b11, 4'b0000, 0, 0, 4'h0, 0, 0,
         ex(1, 4'b0, 0, 0, 0, 0, 0, 1));
    step("hi_nochk", 1, 1, 4'b1000, 2'b00, 4'b0100, 0, 0, 4'b0110, 0, 0,
         ex(1, 4'b0010, 1, 0, 0, 0, 0, 0));
`endif

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, parametrised successor to the ID-stage control decoder. It decodes op_code, mode, S and I into the execute control word and evaluates the ARM condition field against NZCV. It latches the result into the ID/EX control register with freeze/flush handling and squashes branch-shadow slots with a counter. It sits between the instruction decode logic and the EX stage, one cycle of latency.

## Interface
- CMD_W, 4: width of exe_cmd; the 4-bit command is zero-extended into it (must be ≥4).
- BR_SHADOW, 1: accepted slots squashed after a taken branch is latched (0–3).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset: one clock; reset is synchronous and active-low.
- in_valid  in  1  decode slot holds a real instruction.
- cond  in  4  ARM condition field.
- op_code  in  4  data-processing opcode.
- mode  in  2  instruction class (00 data, 01 memory, 10 branch).
- s_in  in  1  S bit (L bit for memory class).
- i_in  in  1  I bit.
- nzcv  in  4  current status flags {N,Z,C,V}.
- freeze  in  1  hold all registers (hazard stall).
- flush  in  1  load a bubble, clear shadow counter.
- out_valid  out  1  ID/EX slot valid.
- exe_cmd  out  CMD_W  ALU command.
- wb_en, mem_r_en, mem_w_en, b_out, s_out  out  1 each  control enables.
- undef  out  1  one-cycle pulse: an undefined encoding was latched.

## Operation
- Decode is fully combinational with a default for every path (no latches). Commands: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, NOP 0000.
- Mode 00, opcodes 1101,1111,0100,0101,0010,0110,0000,1100,0001,1010,1000 map to MOV,MVN,ADD,ADC,SUB,SBC,AND,ORR,EOR,CMP,TST.
  - wb_en=1 except CMP/TST.
  - s_out=s_in, forced 1 for CMP/TST.
- Mode 01, opcode 0100:
  - s_in=1 → LDR (wb_en, mem_r_en).
  - s_in=0 → STR (mem_w_en).
  - s_out=0.
- Mode 10, i_in=1 → branch: b_out=1, exe_cmd=0000, other enables 0.
- Any other encoding → undefined: all enables 0, exe_cmd=0000, out_valid=1, undef=1.
- Condition pass: standard ARM table for cond 0000–1110. 1111 never passes.
- Condition fail → slot latched as bubble: out_valid=0, all enables 0, exe_cmd=0. undef is not raised.
- Shadow counter sc (2 bits):
  - When a passing branch is latched, sc ← BR_SHADOW.
  - While sc≠0, each cycle with in_valid=1 and freeze=0 latches a bubble and decrements sc.
- Priority per cycle: rst_n=0 > flush > freeze > normal latch.
- flush: registers ← bubble, sc ← 0, undef ← 0.
- freeze: all outputs and sc hold, except undef, which drops to 0 (pulse only).
- in_valid=0 latches a bubble and leaves sc unchanged.

## Timing
- Latency 1: inputs sampled at edge k appear on outputs after edge k.
- Reset values: out_valid=0, exe_cmd=0, wb_en=mem_r_en=mem_w_en=b_out=s_out=0, undef=0, sc=0.
- Reset mid-branch-shadow clears sc; the first post-reset instruction is not squashed.
- Branch in the shadow of a branch: squashed, does not reload sc.
- freeze and flush together: flush wins.
- BR_SHADOW=0: no squashing; sc never leaves 0.

## Configuration
- COND_CHECK_EN defined: condition evaluation and bubble-on-fail as above.
- COND_CHECK_EN undefined: the cond and nzcv inputs are ignored and every instruction is treated as passing. The shadow counter and undef behave identically in both builds.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid=1 ADD → all outputs 0. Release, ADD (mode 00, op 0100, s_in=1, cond 1110) → next cycle exe_cmd=0010, wb_en=1, s_out=1, out_valid=1.
- Condition: SUB cond=0000 (EQ) with nzcv=0000 → bubble (out_valid=0). Same with nzcv=0100 → exe_cmd=0100, wb_en=1. Also check CMP → wb_en=0, s_out=1.
- Memory: mode 01, op 0100, s_in=1 → mem_r_en=1, wb_en=1. s_in=0 → mem_w_en=1, wb_en=0. Op 0011 in mode 01 → undef pulses 1 cycle, enables 0.
- Branch shadow, BR_SHADOW=2: B then three ADDs → b_out=1, two bubbles, third ADD valid with exe_cmd=0010.
- Freeze/flush: latch ORR, hold freeze=1 for 3 cycles with changing inputs → outputs stay exe_cmd=0111. Assert flush with freeze=1 → next cycle out_valid=0, sc=0.
- Build without COND_CHECK_EN: cond=1111 ADD → latched valid, exe_cmd=0010.
